if_imem_loader: RTL
===================

// Module: if_imem_loader
// PURPOSE
//   Boot-time writer for the IF-stage instruction memory (1024 x 32-bit words, word-addressed).
//   Accepts a byte stream from a host link (UART/JTAG bridge) and assembles bytes big-endian into words.
//   Writes the words to consecutive memory addresses from 0, and holds the pipeline in reset until the image is in.
//   Sits beside the instruction memory and drives that memory's write port.
// PARAMETERS
//   ADDR_WIDTH  10  word-address width; memory depth DEPTH = 2**ADDR_WIDTH (legal range 1..16)
// PORTS
//   Clk              in   1           rising-edge clock
//   Reset_n          in   1           asynchronous, active-low reset
//   Load_Start       in   1           pulse: begin a new image load
//   Byte_Valid       in   1           Byte_Data is valid
//   Byte_Data        in   8           stream byte
//   Byte_Ready       out  1           loader can accept a byte
//   Imem_Write_En    out  1           one-cycle write strobe to the instruction memory
//   Imem_Write_Addr  out  ADDR_WIDTH  word address
//   Imem_Write_Data  out  32          assembled instruction word
//   CPU_Hold         out  1           keeps PC and pipeline frozen
//   Load_Done        out  1           image loaded (level)
//   Load_Error       out  1           image rejected (level)
// BEHAVIOUR
//   - Reset: state IDLE; every output 0; word index and byte index 0.
//     Reset mid-load returns the block to IDLE at once. Words already written are not erased.
//   - A byte is consumed only on Byte_Valid & Byte_Ready in the same cycle.
//     Byte_Valid gaps stall progress with no timeout.
//   - Stream format: COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then 4*N data bytes.
//     Within each word, the first byte goes to bits [31:24].
//   - FSM states: IDLE, LEN_HI, LEN_LO, DATA, [CHK], DONE, ERROR.
//     IDLE   : Byte_Ready=0, CPU_Hold=0. Load_Start -> LEN_HI.
//     LEN_HI : Byte_Ready=1, CPU_Hold=1. Byte -> LEN_LO.
//     LEN_LO : Byte_Ready=1, CPU_Hold=1. On the byte:
//              N==0 -> DONE; N>DEPTH -> ERROR; otherwise -> DATA.
//     DATA   : Byte_Ready=1 continuously (no back-pressure).
//              Handshake on byte index 3 in cycle T gives Imem_Write_En=1 for exactly cycle T+1,
//              with Addr = word index and Data = the assembled word.
//              After the N-th write, the block reaches DONE (or CHK) and Load_Done is high at T+2.
//     DONE   : Load_Done=1, CPU_Hold=0, Byte_Ready=0. Load_Start -> LEN_HI and clears Load_Done.
//     ERROR  : Load_Error=1, CPU_Hold=1, Byte_Ready=0, no writes. Load_Start -> LEN_HI and clears Load_Error.
//   - Load_Start outside IDLE, DONE and ERROR is ignored. Bytes offered in IDLE, DONE or ERROR are not consumed.
//   - Word index wraps never: N<=DEPTH guarantees the last address is DEPTH-1.
//   - Load_Start in the same cycle as a final write: the write completes, and the restart is taken from DONE on the next pulse only.
// CONFIGURATION
//   CHECKSUM_EN defined:
//     - After the N-th data byte, the FSM enters CHK and accepts one more byte.
//     - That byte is compared with the XOR of all 4*N data bytes (count bytes excluded).
//     - Match -> DONE; mismatch -> ERROR. All N words are written in either case.
//     - N==0 expects checksum 0x00.
//   CHECKSUM_EN undefined: no CHK state; DATA -> DONE directly after the final write.
// TESTING
//   1. Reset_n=0 with random inputs -> all outputs 0. Release -> IDLE, Byte_Ready=0.
//   2. Start, then bytes 00 02 12 34 56 78 9A BC DE F0 ->
//      writes [0]=0x12345678 and [1]=0x9ABCDEF0, each strobe 1 cycle after its 4th byte;
//      Load_Done=1, CPU_Hold=0.
//   3. Start, then bytes 00 00 -> no writes, Load_Done=1.
//      Start, then bytes 04 01 (N=1025, DEPTH=1024) -> Load_Error=1, CPU_Hold=1, no writes.
//   4. Test 2 with Byte_Valid low on alternate cycles -> identical writes.
//      Reset_n pulsed after 5 bytes -> IDLE, Imem_Write_En stays 0 thereafter.
//   5. Load_Start pulsed while in DATA -> ignored.
//      Start from DONE with 00 01 AA BB CC DD -> [0]=0xAABBCCDD, Done.
//   6. CHECKSUM_EN: test 2 stream plus 0x00 -> Done. Same stream plus 0x01 -> Error, both words still written.

Source files
------------

// File: rtl/if_imem_loader.sv
// Boot-time IF-stage instruction-memory loader: assembles a big-endian byte stream into 32-bit words
// written to consecutive addresses from 0. Define CHECKSUM_EN to require a trailing XOR checksum byte.
module if_imem_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Load_Start,
   input  logic                  Byte_Valid,
   input  logic [7:0]            Byte_Data,
   output logic                  Byte_Ready,
   output logic                  Imem_Write_En,
   output logic [ADDR_WIDTH-1:0] Imem_Write_Addr,
   output logic [31:0]           Imem_Write_Data,
   output logic                  CPU_Hold,
   output logic                  Load_Done,
   output logic                  Load_Error
);

   localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
`ifdef CHECKSUM_EN
      S_CHK    = 3'd4,
`endif
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [7:0]            r_countHi;
   logic [15:0]           r_wordsLeft;
   logic [ADDR_WIDTH-1:0] r_wordIdx;
   logic [ADDR_WIDTH-1:0] r_wrAddr;
   logic [1:0]            r_byteIdx;
   logic [23:0]           r_shift;
   logic [31:0]           r_wrData;
   logic                  r_wrEn;
   logic                  w_take;
   logic [15:0]           w_count;
`ifdef CHECKSUM_EN
   logic [7:0]            r_chk;
`endif

   assign w_take          = Byte_Valid & Byte_Ready;
   assign w_count         = {r_countHi, Byte_Data};
   assign Imem_Write_En   = r_wrEn;
   assign Imem_Write_Addr = r_wrAddr;
   assign Imem_Write_Data = r_wrData;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else          r_state <= w_nextState;
   end

   // Without a checksum, DATA lingers one cycle with nothing left so Load_Done follows the final strobe.
   always_comb begin
      w_nextState = r_state;
      Byte_Ready  = 1'b0;
      CPU_Hold    = 1'b0;
      Load_Done   = 1'b0;
      Load_Error  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Load_Start) w_nextState = S_LEN_HI;
         end
         S_LEN_HI: begin
            Byte_Ready = 1'b1;
            CPU_Hold   = 1'b1;
            if (Byte_Valid) w_nextState = S_LEN_LO;
         end
         S_LEN_LO: begin
            Byte_Ready = 1'b1;
            CPU_Hold   = 1'b1;
            if (Byte_Valid) begin
               if (w_count == 16'd0) begin
`ifdef CHECKSUM_EN
                  w_nextState = S_CHK;
`else
                  w_nextState = S_DONE;
`endif
               end else if ({1'b0, w_count} > DEPTH) begin
                  w_nextState = S_ERROR;
               end else begin
                  w_nextState = S_DATA;
               end
            end
         end
         S_DATA: begin
            Byte_Ready = (r_wordsLeft != 16'd0);
            CPU_Hold   = 1'b1;
`ifdef CHECKSUM_EN
            if (w_take && (r_byteIdx == 2'd3) && (r_wordsLeft == 16'd1)) w_nextState = S_CHK;
`else
            if (r_wordsLeft == 16'd0) w_nextState = S_DONE;
`endif
         end
`ifdef CHECKSUM_EN
         S_CHK: begin
            Byte_Ready = 1'b1;
            CPU_Hold   = 1'b1;
            if (Byte_Valid) w_nextState = (Byte_Data == r_chk) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE: begin
            Load_Done = 1'b1;
            if (Load_Start) w_nextState = S_LEN_HI;
         end
         S_ERROR: begin
            Load_Error = 1'b1;
            CPU_Hold   = 1'b1;
            if (Load_Start) w_nextState = S_LEN_HI;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_countHi   <= '0;
         r_wordsLeft <= '0;
         r_wordIdx   <= '0;
         r_wrAddr    <= '0;
         r_byteIdx   <= '0;
         r_shift     <= '0;
         r_wrData    <= '0;
         r_wrEn      <= 1'b0;
`ifdef CHECKSUM_EN
         r_chk       <= '0;
`endif
      end else begin
         r_wrEn <= 1'b0;
         if ((r_state == S_LEN_HI) && w_take) r_countHi <= Byte_Data;
         if ((r_state == S_LEN_LO) && w_take) begin
            r_wordsLeft <= w_count;
            r_wordIdx   <= '0;
            r_byteIdx   <= '0;
`ifdef CHECKSUM_EN
            r_chk       <= '0;
`endif
         end
         if ((r_state == S_DATA) && w_take) begin
            r_byteIdx <= r_byteIdx + 2'd1;
`ifdef CHECKSUM_EN
            r_chk     <= r_chk ^ Byte_Data;
`endif
            if (r_byteIdx == 2'd3) begin
               r_wrEn      <= 1'b1;
               r_wrAddr    <= r_wordIdx;
               r_wrData    <= {r_shift, Byte_Data};
               r_wordIdx   <= r_wordIdx + ADDR_WIDTH'(1);
               r_wordsLeft <= r_wordsLeft - 16'd1;
            end else begin
               r_shift <= {r_shift[15:0], Byte_Data};
            end
         end
      end
   end

endmodule
